pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-width per-field stage registers. One generic pipeline stage (e.g. ID/EX) holding a control bundle and a data bundle.
- Adds valid/ready handshake, a 2-entry skid buffer for full throughput with registered in_ready, and flush that zeroes control only.
- Instantiated between stages in place of per-field register stacks; hazard unit drives flush and consumer back-pressure.

---
 rtl/pipe_stage_skid_pkg.sv | 40 ++++
 rtl/pipe_stage_skid_slot.sv | 29 ++
 rtl/pipe_stage_skid.sv | 91 +++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: stage state encoding and the bundle layouts of the ID/EX, EX/MEM and MEM/WB stages.
package pipe_stage_skid_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;
  localparam int IDEX_CTRL_W    = 9;
  localparam int IDEX_REGDST    = 0;
  localparam int IDEX_ALUSRC    = 1;
  localparam int IDEX_ALUCTRL_O = 2;
  localparam int IDEX_ALUCTRL_W = 4;
  localparam int IDEX_MEMWRITE  = 6;
  localparam int IDEX_MEMTOREG  = 7;
  localparam int IDEX_REGWRITE  = 8;
  localparam int IDEX_DATA_W    = 111;
  localparam int IDEX_RD_O      = 0;
  localparam int IDEX_RT_O      = 5;
  localparam int IDEX_RS_O      = 10;
  localparam int IDEX_IMM_O     = 15;
  localparam int IDEX_RD2_O     = 47;
  localparam int IDEX_RD1_O     = 79;
  localparam int REG_W          = 5;
  localparam int WORD_W         = 32;
  localparam int EXMEM_CTRL_W   = 3;
  localparam int EXMEM_MEMWRITE = 0;
  localparam int EXMEM_MEMTOREG = 1;
  localparam int EXMEM_REGWRITE = 2;
  localparam int EXMEM_DATA_W   = 69;
  localparam int EXMEM_WREG_O   = 0;
  localparam int EXMEM_WDATA_O  = 5;
  localparam int EXMEM_ALUOUT_O = 37;
  localparam int MEMWB_CTRL_W   = 2;
  localparam int MEMWB_MEMTOREG = 0;
  localparam int MEMWB_REGWRITE = 1;
  localparam int MEMWB_DATA_W   = 69;
  localparam int MEMWB_WREG_O   = 0;
  localparam int MEMWB_ALUOUT_O = 5;
  localparam int MEMWB_RDATA_O  = 37;
endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one stage entry; control can be cleared on its own while the data keeps its value.
module pipe_slot #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      if (clr_i) ctrl_q <= '0;
      else if (ld_i) ctrl_q <= ctrl_i;
      if (ld_i) data_q <= data_i;
    end
  end
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and ctrl-only flush.
// Define PIPE_STAGE_SKID_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  state_e state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic acc, drn, hd_ld, sk_ld;
  logic [CTRL_W-1:0] hd_ctrl, sk_ctrl;
  logic [DATA_W-1:0] hd_data, sk_data;
  assign out_valid = state_q != ST_EMPTY;
  assign in_ready  = in_ready_q;
  assign acc       = in_valid && in_ready_q;
  assign drn       = out_valid && out_ready;
  always_comb begin
    state_d = flush ? ST_EMPTY :
              state_q == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE ? (acc && !drn ? ST_TWO : !acc && drn ? ST_EMPTY : ST_ONE) :
              (drn ? ST_ONE : ST_TWO);
    in_ready_d = state_d != ST_TWO;
    // head refills from skid when draining out of TWO, otherwise from the input
    hd_ld = !flush && (state_q == ST_TWO ? drn : acc && (state_q == ST_EMPTY || drn));
    sk_ld = !flush && state_q == ST_ONE && acc && !drn;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (hd_ld),
    .clr_i  (flush),
    .ctrl_i (state_q == ST_TWO ? sk_ctrl : in_ctrl),
    .data_i (state_q == ST_TWO ? sk_data : in_data),
    .ctrl_o (hd_ctrl),
    .data_o (hd_data)
  );
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (sk_ld),
    .clr_i  (flush),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (sk_ctrl),
    .data_o (sk_data)
  );
  assign out_ctrl = out_valid ? hd_ctrl : '0;
  assign out_data = hd_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush && out_valid && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of streaming, back-pressure, flush and async reset for pipe_stage_skid.
module tb_pipe_stage_skid;
  localparam int CW = 9;
  localparam int DW = 111;
  localparam int NW = 4;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready, in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  int cmp_n = 0;
  int err_n = 0;
  int drained = 0;
  logic [CW-1:0] last_ctrl = '0;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [NW-1:0] stall_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );
  always @(posedge clk)
    if (rst_n && out_valid && out_ready) begin
      drained++;
      last_ctrl = out_ctrl;
    end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {DW{1'b0}} | (DW'(c) << 40) | DW'(c);
  endtask
  function automatic logic [DW-1:0] dat(input logic [CW-1:0] c);
    return {DW{1'b0}} | (DW'(c) << 40) | DW'(c);
  endfunction
  initial begin
    int d0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    step(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();
    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(CW'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_ctrl", out_ctrl, i);
      chk("stream_data", out_data, dat(CW'(i)));
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", out_valid, 0);
    chk("stream_drained", drained, 8);
    // back-pressure fills the skid
    out_ready = 1'b0;
    send(9'h1A);
    step();
    chk("bp_head", out_ctrl, 9'h1A);
    chk("bp_rdy_one", in_ready, 1);
    send(9'h1B);
    step();
    chk("bp_hold_1a", out_ctrl, 9'h1A);
    chk("bp_rdy_two", in_ready, 0);
    send(9'h1C);
    step();
    chk("bp_still_1a", out_ctrl, 9'h1A);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_out_1b", out_ctrl, 9'h1B);
    chk("bp_last_1a", last_ctrl, 9'h1A);
    chk("bp_rdy_back", in_ready, 1);
    step();
    chk("bp_out_1c", out_ctrl, 9'h1C);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_last_1c", last_ctrl, 9'h1C);
    chk("bp_count", drained, 11);
    // flush while TWO with a concurrent beat offered
    out_ready = 1'b0;
    send(9'h11);
    step();
    send(9'h12);
    step();
    chk("fl_two", in_ready, 0);
    send(9'h1D);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data_kept", out_data, dat(9'h11));
    out_ready = 1'b1;
    step(3);
    chk("fl_no_1d", out_valid, 0);
    chk("fl_no_drain", drained, 11);
    // flush while the head drains
    send(9'h05);
    step();
    in_valid = 1'b0;
    chk("fd_head", out_ctrl, 9'h05);
    d0 = drained;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fd_drained", drained, d0 + 1);
    chk("fd_last", last_ctrl, 9'h05);
    chk("fd_empty", out_valid, 0);
    chk("fd_ready", in_ready, 1);
    // flush held several cycles
    flush = 1'b1;
    send(9'h33);
    step(3);
    chk("fh_empty", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fh_still_empty", out_valid, 0);
    // async reset mid-stream
    out_ready = 1'b0;
    send(9'h44);
    step();
    send(9'h45);
    step();
    chk("ar_pre_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_ready", in_ready, 1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`ifdef PIPE_STAGE_SKID_PERF_EN
    chk("pf_rst_stall", stall_cnt, 0);
    chk("pf_rst_flush", flush_cnt, 0);
    out_ready = 1'b0;
    send(9'h07);
    step();
    in_valid = 1'b0;
    step(5);
    chk("pf_stall5", stall_cnt, 5);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    send(9'h08);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("pf_stall_same", stall_cnt, 5);
    chk("pf_flush2", flush_cnt, 2);
    out_ready = 1'b0;
    send(9'h09);
    step();
    in_valid = 1'b0;
    step(20);
    chk("pf_stall_sat", stall_cnt, 15);
    for (int i = 0; i < 16; i++) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      send(9'h0A);
      step();
      in_valid = 1'b0;
    end
    chk("pf_flush_sat", flush_cnt, 15);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
